// File: rtl/tnn_seq_threshold_neuron.sv
// Streaming threshold neuron: accumulates signed +/-1-weighted channel sums per frame and emits (acc > THRESH).
// Optional macro TNN_ACC_SAT_EN: saturate the accumulator instead of wrapping modulo 2^ACC_W.
module tnn_seq_threshold_neuron #(
    parameter int               NCH       = 5,
    parameter int               W         = 3,
    parameter logic [NCH-1:0]   POS_MASK  = 5'b10110,
    parameter int               ACC_W     = 12,
    parameter int               THRESH    = 0,
    parameter int               MAX_BEATS = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NCH*W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_bit,
    output logic             out_trunc
);

    localparam int                      CNT_W    = $clog2(MAX_BEATS + 1);
    localparam logic signed [ACC_W-1:0] THRESH_S = ACC_W'(THRESH);
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(MAX_BEATS - 1);
    localparam logic [0:0]              ST_ACCUM = 1'b0;
    localparam logic [0:0]              ST_HOLD  = 1'b1;

    logic [0:0]              state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        beat_cnt;
    logic signed [ACC_W-1:0] beat_sum;
    logic signed [ACC_W-1:0] acc_next;
    logic                    accept;
    logic                    frame_end;

    function automatic logic signed [ACC_W-1:0] acc_add(
        input logic signed [ACC_W-1:0] a,
        input logic signed [ACC_W-1:0] b
    );
`ifdef TNN_ACC_SAT_EN
        logic [ACC_W:0] wide;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        // Sign bits disagree only when the true sum left the ACC_W range.
        if (wide[ACC_W] != wide[ACC_W-1])
            acc_add = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            acc_add = wide[ACC_W-1:0];
`else
        acc_add = a + b;
`endif
    endfunction

    always_comb begin : beat_sum_calc
        logic signed [ACC_W-1:0] ch;
        beat_sum = '0;
        ch       = '0;
        for (int i = 0; i < NCH; i++) begin
            ch = ACC_W'(in_data[i*W +: W]);
            if (POS_MASK[i])
                beat_sum = beat_sum + ch;
            else
                beat_sum = beat_sum - ch;
        end
    end

    // Input stalls only while a finished result is waiting to be consumed.
    assign in_ready  = rst_n && ((state == ST_ACCUM) || out_ready);
    assign accept    = in_valid && in_ready;
    assign frame_end = in_last || (beat_cnt == LAST_CNT);
    assign acc_next  = acc_add(acc, beat_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
            out_trunc <= 1'b0;
        end else begin
            if (state == ST_HOLD && out_ready) begin
                out_valid <= 1'b0;
                state     <= ST_ACCUM;
            end
            // A frame-ending beat overrides the retire above, giving back-to-back results.
            if (accept) begin
                if (frame_end) begin
                    out_bit   <= (acc_next > THRESH_S);
                    out_trunc <= !in_last;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    beat_cnt  <= '0;
                    state     <= ST_HOLD;
                end else begin
                    acc      <= acc_next;
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tnn_seq_threshold_neuron.sv
// Self-checking bench for tnn_seq_threshold_neuron: directed vector table, corner sequences, randomized model check.
module tb_tnn_seq_threshold_neuron;

    localparam logic [4:0] MASK = 5'b10110;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_last, out_ready;
    logic [14:0] in_data;
    logic        o_rdy, o_valid, o_bit, o_trunc;
    logic        t_rdy, t_valid, t_bit, t_trunc;
    logic        s_rdy, s_valid, s_bit, s_trunc;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tnn_seq_threshold_neuron dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o_rdy), .in_data(in_data),
        .in_last(in_last), .out_valid(o_valid), .out_ready(out_ready), .out_bit(o_bit), .out_trunc(o_trunc)
    );

    tnn_seq_threshold_neuron #(.THRESH(1)) dut_t1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_rdy), .in_data(in_data),
        .in_last(in_last), .out_valid(t_valid), .out_ready(out_ready), .out_bit(t_bit), .out_trunc(t_trunc)
    );

    tnn_seq_threshold_neuron #(.ACC_W(6)) dut_a6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_rdy), .in_data(in_data),
        .in_last(in_last), .out_valid(s_valid), .out_ready(out_ready), .out_bit(s_bit), .out_trunc(s_trunc)
    );

    typedef struct {
        logic [14:0] data;
        logic        last;
        logic        exp_bit;
        logic        exp_t1;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [14:0] pk(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                                       input logic [2:0] d, input logic [2:0] e);
        return {e, d, c, b, a};
    endfunction

    function automatic int model_sum(input logic [14:0] d);
        int s = 0;
        for (int i = 0; i < 5; i++) begin
            int ch = int'(d[i*3 +: 3]);
            s = MASK[i] ? s + ch : s - ch;
        end
        return s;
    endfunction

    function automatic int model_acc(input int acc, input int s, input int accw);
        int lo = -(1 << (accw - 1));
        int hi = (1 << (accw - 1)) - 1;
        int m  = 1 << accw;
        int t  = acc + s;
`ifdef TNN_ACC_SAT_EN
        if (t > hi) t = hi;
        if (t < lo) t = lo;
`else
        t = ((t - lo) % m + m) % m + lo;
        if (t > hi) t = hi;
`endif
        return t;
    endfunction

    initial begin
        vec_t tbl [6];
        int   m_acc, m_cnt;
        logic p_valid, p_bit, p_trunc, exp_rdy, acc_ok;

        tbl[0] = '{pk(7, 7, 7, 0, 0), 1'b1, 1'b1, 1'b1};
        tbl[1] = '{pk(7, 3, 3, 7, 3), 1'b1, 1'b0, 1'b0};
        tbl[2] = '{pk(3, 3, 0, 0, 0), 1'b1, 1'b0, 1'b0};
        tbl[3] = '{pk(0, 4, 0, 0, 0), 1'b0, 1'b0, 1'b0};
        tbl[4] = '{pk(2, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0};
        tbl[5] = '{pk(0, 0, 0, 1, 0), 1'b1, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b1; in_data = pk(7, 7, 7, 7, 7); out_ready = 1'b1;
        #1;
        check("reset_in_ready", o_rdy, 0);
        tick();
        check("reset_out_valid", o_valid, 0);
        check("reset_out_bit", o_bit, 0);
        check("reset_out_trunc", o_trunc, 0);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Directed vector table
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = tbl[i].data; in_last = tbl[i].last; out_ready = 1'b1;
            #1;
            check("tbl_in_ready", o_rdy, 1);
            tick();
            check("tbl_out_valid", o_valid, tbl[i].last);
            if (tbl[i].last) begin
                check("tbl_out_bit", o_bit, tbl[i].exp_bit);
                check("tbl_out_trunc", o_trunc, 0);
                check("tbl_t1_bit", t_bit, tbl[i].exp_t1);
                check("tbl_t1_valid", t_valid, 1);
            end
        end
        in_valid = 1'b0;
        tick();
        check("idle_out_valid", o_valid, 0);

        // Forced close at 16 beats, then a fresh frame from zero
        for (int b = 1; b <= 16; b++) begin
            in_valid = 1'b1; in_data = pk(0, 1, 0, 0, 0); in_last = 1'b0;
            tick();
            check("trunc_out_valid", o_valid, (b == 16));
        end
        check("trunc_out_bit", o_bit, 1);
        check("trunc_out_trunc", o_trunc, 1);
        in_data = pk(1, 0, 0, 0, 0); in_last = 1'b1;
        tick();
        check("post_trunc_valid", o_valid, 1);
        check("post_trunc_bit", o_bit, 0);
        check("post_trunc_trunc", o_trunc, 0);
        in_valid = 1'b0;
        tick();

        // Back-pressure hold then release with a 1-beat frame waiting
        in_valid = 1'b1; in_data = pk(7, 7, 7, 0, 0); in_last = 1'b1; out_ready = 1'b0;
        tick();
        check("bp_first_valid", o_valid, 1);
        in_data = pk(7, 0, 0, 0, 0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", o_rdy, 0);
            tick();
            check("bp_out_valid", o_valid, 1);
            check("bp_out_bit", o_bit, 1);
            check("bp_out_trunc", o_trunc, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", o_rdy, 1);
        tick();
        check("bp_release_valid", o_valid, 1);
        check("bp_release_bit", o_bit, 0);
        in_valid = 1'b0;
        tick();
        check("bp_drain_valid", o_valid, 0);

        // ACC_W=6 overflow: three beats of +21
        do_reset();
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1; in_data = pk(0, 7, 7, 0, 7); in_last = (b == 2);
            tick();
        end
        check("ovf_a6_valid", s_valid, 1);
        check("ovf_a6_trunc", s_trunc, 0);
`ifdef TNN_ACC_SAT_EN
        check("ovf_a6_bit", s_bit, 1);
`else
        check("ovf_a6_bit", s_bit, 0);
`endif
        check("ovf_wide_bit", o_bit, 1);
        in_valid = 1'b0;
        tick();

        // Reset mid-frame discards the partial sum
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1; in_data = pk(0, 7, 0, 0, 0); in_last = 1'b0;
            tick();
        end
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        check("midrst_in_ready", o_rdy, 0);
        tick();
        check("midrst_valid", o_valid, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_no_output", o_valid, 0);
        in_valid = 1'b1; in_data = pk(3, 0, 0, 0, 0); in_last = 1'b1;
        tick();
        check("midrst_new_valid", o_valid, 1);
        check("midrst_new_bit", o_bit, 0);
        in_valid = 1'b0;
        tick();

        // Randomized traffic against a transaction-level model
        do_reset();
        m_acc = 0; m_cnt = 0; p_valid = 1'b0; p_bit = 1'b0; p_trunc = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 15'($urandom);
            in_last   = ($urandom_range(0, 7) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = !p_valid || out_ready;
            check("rnd_in_ready", o_rdy, exp_rdy);
            acc_ok = in_valid && exp_rdy;
            if (p_valid && out_ready) p_valid = 1'b0;
            if (acc_ok) begin
                m_acc = model_acc(m_acc, model_sum(in_data), 12);
                m_cnt++;
                if (in_last || m_cnt == 16) begin
                    p_valid = 1'b1;
                    p_bit   = (m_acc > 0);
                    p_trunc = !in_last;
                    m_acc   = 0;
                    m_cnt   = 0;
                end
            end
            tick();
            check("rnd_out_valid", o_valid, p_valid);
            if (p_valid) begin
                check("rnd_out_bit", o_bit, p_bit);
                check("rnd_out_trunc", o_trunc, p_trunc);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
